dirty_flush_walker: RTL and testbench

// - Reader/clearer for an 8-entry set/reset status array (cache dirty/valid bits).
// - On a flush command, walks every index, issues one writeback request per set bit,

---
 rtl/dirty_flush_walker_pkg.sv | 21 ++
 rtl/dirty_flush_walker_if.sv | 47 ++++
 rtl/dirty_flush_walker.sv | 110 +++++++++++
 tb/tb_dirty_flush_walker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dirty_flush_walker_pkg.sv
// Shared types and sizing for the dirty-bit flush walker.
package dirty_flush_walker_pkg;

    localparam int unsigned NUM_ENTRIES = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned CNT_W       = 4;

    typedef logic [IDX_W-1:0] status_idx_t;
    typedef logic [CNT_W-1:0] flush_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WB,
        CLEAR,
        DONE
    } flush_state_t;

    localparam status_idx_t IDX_LAST = status_idx_t'(NUM_ENTRIES - 1);

endpackage

// File: rtl/dirty_flush_walker_if.sv
// Command, status-array and writeback signals of the flush walker.
interface dirty_flush_walker_if;
    import dirty_flush_walker_pkg::*;

    logic        flush_start;
    logic        busy;
    logic        flush_done;
    flush_cnt_t  flushed_count;
    status_idx_t arr_index;
    logic        arr_dataout;
    logic        arr_enable;
    logic        arr_reset;
    logic        wb_req;
    status_idx_t wb_index;
    logic        wb_resp;

    // Walker side
    modport master (
        input  flush_start,
        input  arr_dataout,
        input  wb_resp,
        output busy,
        output flush_done,
        output flushed_count,
        output arr_index,
        output arr_enable,
        output arr_reset,
        output wb_req,
        output wb_index
    );

    // Cache control / array / memory side
    modport slave (
        output flush_start,
        output arr_dataout,
        output wb_resp,
        input  busy,
        input  flush_done,
        input  flushed_count,
        input  arr_index,
        input  arr_enable,
        input  arr_reset,
        input  wb_req,
        input  wb_index
    );

endinterface

// File: rtl/dirty_flush_walker.sv
// Walks the status array on a flush command, writing back and clearing every set bit.
module dirty_flush_walker
    import dirty_flush_walker_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    dirty_flush_walker_if.master bus
);

    flush_state_t r_state;
    flush_state_t w_state_d;
    status_idx_t  r_idx;
    status_idx_t  w_idx_d;
    flush_cnt_t   r_count;
    flush_cnt_t   w_count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_count <= w_count_d;
        end
    end

    // idx stops at IDX_LAST; the last entry always exits to DONE instead of incrementing
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_count_d = r_count;
        unique case (r_state)
            IDLE: begin
                if (bus.flush_start) begin
                    w_state_d = SCAN;
                    w_idx_d   = '0;
                    w_count_d = '0;
                end
            end
            SCAN: begin
                if (bus.arr_dataout) begin
                    w_state_d = WB;
                end else if (r_idx == IDX_LAST) begin
                    w_state_d = DONE;
                end else begin
                    w_idx_d = r_idx + status_idx_t'(1);
                end
            end
            WB: begin
                if (bus.wb_resp) begin
                    w_state_d = CLEAR;
                    w_count_d = r_count + flush_cnt_t'(1);
                end
            end
            CLEAR: begin
                if (r_idx == IDX_LAST) begin
                    w_state_d = DONE;
                end else begin
                    w_state_d = SCAN;
                    w_idx_d   = r_idx + status_idx_t'(1);
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy          = 1'b0;
        bus.flush_done    = 1'b0;
        bus.flushed_count = r_count;
        bus.arr_index     = '0;
        bus.arr_enable    = 1'b0;
        bus.arr_reset     = 1'b0;
        bus.wb_req        = 1'b0;
        bus.wb_index      = '0;
        unique case (r_state)
            IDLE: ;
            SCAN: begin
                bus.busy      = 1'b1;
                bus.arr_index = r_idx;
            end
            WB: begin
                bus.busy      = 1'b1;
                bus.arr_index = r_idx;
                bus.wb_req    = 1'b1;
                bus.wb_index  = r_idx;
            end
            CLEAR: begin
                bus.busy       = 1'b1;
                bus.arr_index  = r_idx;
                bus.arr_enable = 1'b1;
                bus.arr_reset  = 1'b1;
            end
            DONE: begin
                bus.busy       = 1'b1;
                bus.flush_done = 1'b1;
                bus.arr_index  = r_idx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dirty_flush_walker.sv
// Self-checking bench: status-array model, writeback responder and a writeback/clear scoreboard.
module tb_dirty_flush_walker;
    import dirty_flush_walker_pkg::*;

    logic clk;
    logic reset;

    dirty_flush_walker_if u_if ();

    dirty_flush_walker u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Status-array model: sets from the bench, clears from the walker
    logic [7:0] arr;
    logic [7:0] set_mask;
    always @(posedge clk) begin
        arr <= (arr | set_mask) &
               ~((u_if.arr_enable && u_if.arr_reset) ? (8'h01 << u_if.arr_index) : 8'h00);
    end
    assign u_if.arr_dataout = arr[u_if.arr_index];

    // Writeback responder
    logic resp_en;
    int   resp_dly;
    logic resp_auto;
    logic resp_manual;
    assign u_if.wb_resp = resp_auto | resp_manual;

    always begin
        @(negedge clk);
        if (resp_en && u_if.wb_req && !resp_auto) begin
            repeat (resp_dly) @(negedge clk);
            if (u_if.wb_req) resp_auto = 1'b1;
            @(negedge clk);
            resp_auto = 1'b0;
        end
    end

    // Scoreboard: expected writeback and clear indices in issue order
    int   wb_q[$];
    int   clr_q[$];
    int   wb_seen;
    logic prev_req;
    always @(negedge clk) begin
        if (u_if.wb_req && !prev_req) begin
            wb_seen++;
            if (wb_q.size() == 0) chk("wb_extra", 32'(u_if.wb_index), 32'd8);
            else chk("wb_index", 32'(u_if.wb_index), 32'(wb_q.pop_front()));
        end
        if (u_if.arr_reset) begin
            if (clr_q.size() == 0) chk("clr_extra", 32'(u_if.arr_index), 32'd8);
            else chk("clr_index", 32'(u_if.arr_index), 32'(clr_q.pop_front()));
        end
        prev_req = u_if.wb_req;
    end

    task automatic preload(input logic [7:0] mask);
        @(negedge clk);
        set_mask = mask;
        @(negedge clk);
        set_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                wb_q.push_back(i);
                clr_q.push_back(i);
            end
        end
    endtask

    task automatic run_flush(input int exp_lat, input int exp_cnt);
        int   cyc;
        logic done;
        cyc  = 0;
        done = 1'b0;
        @(negedge clk);
        u_if.flush_start = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            u_if.flush_start = 1'b0;
            if (u_if.flush_done) done = 1'b1;
        end
        chk("flush_done_seen", 32'(done), 32'd1);
        if (done) chk("busy_in_done", 32'(u_if.busy), 32'd1);
        if (exp_lat >= 0) chk("flush_latency", 32'(cyc), 32'(exp_lat));
        chk("flushed_count", 32'(u_if.flushed_count), 32'(exp_cnt));
        @(negedge clk);
        chk("idle_after_done", 32'({u_if.busy, u_if.flush_done}), 32'd0);
    endtask

    task automatic wait_req(output logic seen);
        int cyc;
        cyc  = 0;
        seen = u_if.wb_req;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            seen = u_if.wb_req;
        end
        chk("wb_req_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, 32'({u_if.busy, u_if.flush_done, u_if.flushed_count, u_if.arr_index,
                      u_if.arr_enable, u_if.arr_reset, u_if.wb_req, u_if.wb_index}), 32'd0);
    endtask

    initial begin
        int   seen_before;
        int   cyc;
        logic seen;
        n_vec            = 0;
        n_err            = 0;
        wb_seen          = 0;
        prev_req         = 1'b0;
        arr              = 8'h00;
        set_mask         = 8'h00;
        resp_en          = 1'b1;
        resp_dly         = 0;
        resp_auto        = 1'b0;
        resp_manual      = 1'b0;
        u_if.flush_start = 1'b0;
        reset            = 1'b1;

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset_outputs");
        reset = 1'b0;

        // Empty array
        seen_before = wb_seen;
        run_flush(9, 0);
        chk("empty_no_wb_req", 32'(wb_seen - seen_before), 32'd0);

        // Bits 2 and 7, slow memory
        resp_dly = 3;
        preload(8'h84);
        run_flush(-1, 2);
        chk("arr_clean_2_7", 32'(arr), 32'd0);

        // All set, same-cycle response
        resp_dly = 0;
        preload(8'hff);
        run_flush(1 + 8 * 3, 8);
        chk("arr_clean_all", 32'(arr), 32'd0);

        // Start re-pulsed in WB and DONE, stray wb_resp in IDLE
        resp_dly = 3;
        preload(8'h20);
        @(negedge clk);
        u_if.flush_start = 1'b1;
        @(negedge clk);
        u_if.flush_start = 1'b0;
        wait_req(seen);
        u_if.flush_start = 1'b1;
        @(negedge clk);
        u_if.flush_start = 1'b0;
        cyc = 0;
        while (!u_if.flush_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("repulse_done_seen", 32'(u_if.flush_done), 32'd1);
        u_if.flush_start = 1'b1;
        @(negedge clk);
        u_if.flush_start = 1'b0;
        chk("repulse_idle", 32'(u_if.busy), 32'd0);
        chk("repulse_count", 32'(u_if.flushed_count), 32'd1);
        resp_en     = 1'b0;
        resp_manual = 1'b1;
        @(negedge clk);
        resp_manual = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_resp_state", 32'({u_if.busy, u_if.wb_req, u_if.flush_done}), 32'd0);
        chk("stray_resp_count", 32'(u_if.flushed_count), 32'd1);
        chk("arr_clean_5", 32'(arr), 32'd0);

        // Reset mid-writeback
        preload(8'h10);
        clr_q.delete();
        @(negedge clk);
        u_if.flush_start = 1'b1;
        @(negedge clk);
        u_if.flush_start = 1'b0;
        wait_req(seen);
        reset = 1'b1;
        #1;
        chk_outputs_zero("midwalk_reset_outputs");
        chk("bit4_kept", 32'(arr[4]), 32'd1);
        @(negedge clk);
        reset   = 1'b0;
        resp_en = 1'b1;
        wb_q.push_back(4);
        clr_q.push_back(4);
        run_flush(-1, 1);
        chk("arr_clean_4", 32'(arr), 32'd0);

        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        chk("clr_q_drained", 32'(clr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
